// File: rtl/fp_operand_gen.sv
// Purpose: on-chip source of pseudo-random IEEE-754 single-precision A/B pairs for divider error runs.
// Latency: first pair valid 1 cycle after start is sampled (plus 1 cycle per filtered candidate); at most one pair per 2 cycles.
// Backpressure: a presented pair holds A/B stable with out_valid high until out_ready; the generators pause meanwhile.
module fp_operand_gen #(
    parameter int          XLEN           = 32,
    parameter int          NUM_SAMPLES    = 20000,
    parameter logic [31:0] SEED_A         = 32'h3F800000,
    parameter logic [31:0] SEED_B         = 32'h40490FDB,
    parameter bit          FILTER_SPECIAL = 1'b1,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  A,
    output logic [XLEN-1:0]  B,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] rejected_count
);

    // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
    localparam logic [XLEN-1:0]  LFSR_MASK   = XLEN'(32'h80200003);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [XLEN-1:0]  SEED_A_EFF  = (SEED_A == 32'd0) ? XLEN'(1) : XLEN'(SEED_A);
    localparam logic [XLEN-1:0]  SEED_B_EFF  = (SEED_B == 32'd0) ? XLEN'(1) : XLEN'(SEED_B);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NUM_SAMP_C  = CNT_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] lfsr_a;
    logic [XLEN-1:0] lfsr_b;
    logic [XLEN-1:0] next_a;
    logic [XLEN-1:0] next_b;
    logic            reject;
    logic            handshake;
    logic            last_sample;
    logic            clear_counts;
    logic            accept_cand;

    function automatic logic [XLEN-1:0] lfsr_step(input logic [XLEN-1:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
    endfunction

    // Zero exponent covers zero/denormal, all-ones covers inf/NaN.
    function automatic logic is_special(input logic [XLEN-1:0] v);
        return (v[30:23] == 8'h00) || (v[30:23] == 8'hFF);
    endfunction

    // Candidate pair and handshake qualifiers derived from current state.
    always_comb begin
        next_a       = lfsr_step(lfsr_a);
        next_b       = lfsr_step(lfsr_b);
        reject       = FILTER_SPECIAL && (is_special(next_a) || is_special(next_b));
        accept_cand  = (state_q == GEN) && !reject;
        handshake    = (state_q == HOLD) && out_ready;
        last_sample  = (sample_count + CNT_ONE) == NUM_SAMP_C;
        clear_counts = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only matters when not running; HOLD leaves only on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)       state_d = GEN;
            GEN:  if (!reject)     state_d = HOLD;
            HOLD: if (out_ready)   state_d = last_sample ? DONE : GEN;
            DONE: if (start)       state_d = GEN;
            default:               state_d = IDLE;
        endcase
    end

    // Both generators advance together, once per candidate, and only while generating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_a <= SEED_A_EFF;
            lfsr_b <= SEED_B_EFF;
        end else if (state_q == GEN) begin
            lfsr_a <= next_a;
            lfsr_b <= next_b;
        end
    end

    // Output pair register; A/B keep the last pair after the handshake and in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A         <= '0;
            B         <= '0;
            out_valid <= 1'b0;
        end else if (accept_cand) begin
            A         <= next_a;
            B         <= next_b;
            out_valid <= 1'b1;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Per-run counters; rejected_count saturates, sample_count stops at NUM_SAMPLES by construction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_count   <= '0;
            rejected_count <= '0;
        end else if (clear_counts) begin
            sample_count   <= '0;
            rejected_count <= '0;
        end else begin
            if ((state_q == GEN) && reject && (rejected_count != CNT_MAX)) begin
                rejected_count <= rejected_count + CNT_ONE;
            end
            if (handshake) begin
                sample_count <= sample_count + CNT_ONE;
            end
        end
    end

    assign busy = (state_q == GEN) || (state_q == HOLD);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_fp_operand_gen.sv
module tb_fp_operand_gen;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;

    logic        v0, v1, v2, busy0, busy1, busy2, done0, done1, done2;
    logic [31:0] a0, b0, a1, b1, a2, b2;
    logic [31:0] sc0, rc0, sc1, rc1, sc2, rc2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Default seeds, filter on, short run: the instance the model tracks.
    fp_operand_gen #(.NUM_SAMPLES(NS)) u0 (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .out_valid(v0), .A(a0), .B(b0), .busy(busy0), .done(done0),
        .sample_count(sc0), .rejected_count(rc0));

    // SEED_A=1 with the filter: first candidate has a zero exponent.
    fp_operand_gen #(.NUM_SAMPLES(NS), .SEED_A(32'h00000001), .FILTER_SPECIAL(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .out_valid(v1), .A(a1), .B(b1), .busy(busy1), .done(done1),
        .sample_count(sc1), .rejected_count(rc1));

    // SEED_A=1 without the filter: the same candidate is presented.
    fp_operand_gen #(.NUM_SAMPLES(NS), .SEED_A(32'h00000001), .FILTER_SPECIAL(1'b0)) u2 (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .out_valid(v2), .A(a2), .B(b2), .busy(busy2), .done(done2),
        .sample_count(sc2), .rejected_count(rc2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model of u0 ----------------
    localparam int S_IDLE = 0, S_GEN = 1, S_HOLD = 2, S_DONE = 3;
    int          m_st;
    logic [31:0] m_la, m_lb, m_a, m_b, m_na, m_nb;
    bit          m_vld;
    int          m_sc, m_rc;

    function automatic logic [31:0] gal(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    function automatic bit special(input logic [31:0] x);
        int e;
        e = int'((x >> 23) & 32'hFF);
        return (e == 0) || (e == 255);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = S_IDLE; m_la = 32'h3F800000; m_lb = 32'h40490FDB;
            m_a = 0; m_b = 0; m_vld = 0; m_sc = 0; m_rc = 0;
        end else begin
            case (m_st)
                S_IDLE, S_DONE: if (start) begin
                    m_sc = 0; m_rc = 0; m_st = S_GEN;
                end
                S_GEN: begin
                    m_na = gal(m_la); m_nb = gal(m_lb);
                    m_la = m_na; m_lb = m_nb;
                    if (special(m_na) || special(m_nb)) begin
                        m_rc++;
                    end else begin
                        m_a = m_na; m_b = m_nb; m_vld = 1; m_st = S_HOLD;
                    end
                end
                S_HOLD: if (out_ready) begin
                    m_vld = 0; m_sc++;
                    m_st = (m_sc == NS) ? S_DONE : S_GEN;
                end
                default: m_st = S_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of u0 against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("cyc out_valid", {31'b0, v0}, {31'b0, m_vld});
            chk("cyc A", a0, m_a);
            chk("cyc B", b0, m_b);
            chk("cyc busy", {31'b0, busy0}, {31'b0, (m_st == S_GEN || m_st == S_HOLD)});
            chk("cyc done", {31'b0, done0}, {31'b0, (m_st == S_DONE)});
            chk("cyc sample_count", sc0, 32'(m_sc));
            chk("cyc rejected_count", rc0, 32'(m_rc));
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < 200) begin tick(); n++; end
        chk(name, {31'b0, done0}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (v0 !== 1'b1 && n < 200) begin tick(); n++; end
        chk(name, {31'b0, v0}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset out_valid", {31'b0, v0}, 32'd0);
        chk("reset busy", {31'b0, busy0}, 32'd0);
        chk("reset done", {31'b0, done0}, 32'd0);
        chk("reset A", a0, 32'h0);
        chk("reset B", b0, 32'h0);
        chk("reset sample_count", sc0, 32'd0);
        chk("reset rejected_count", rc0, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Run 1: free-flowing consumer.
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("gen busy", {31'b0, busy0}, 32'd1);
        chk("gen no valid", {31'b0, v0}, 32'd0);
        tick();
        chk("first valid", {31'b0, v0}, 32'd1);
        chk("first A", a0, 32'h1FC00000);
        chk("first B", b0, 32'hA00487EE);
        chk("nofilt valid", {31'b0, v2}, 32'd1);
        chk("nofilt A", a2, 32'h80200003);
        chk("nofilt B", b2, 32'hA00487EE);
        chk("filt no valid", {31'b0, v1}, 32'd0);
        chk("filt rejected", rc1, 32'd1);
        tick();
        chk("first handshake count", sc0, 32'd1);
        chk("first handshake drop", {31'b0, v0}, 32'd0);
        wait_done("run1 done");
        chk("run1 count", sc0, 32'd4);
        chk("run1 not busy", {31'b0, busy0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no fifth valid", {31'b0, v0}, 32'd0);
        end

        // Run 2: backpressure, start ignored in HOLD.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            chk("bp valid", {31'b0, v0}, 32'd1);
            chk("bp A", a0, 32'h1FC00000);
            chk("bp B", b0, 32'hA00487EE);
            chk("bp count", sc0, 32'd0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp release count", sc0, 32'd1);
        out_ready = 1'b0;
        wait_valid("second pair valid");

        // Asynchronous reset while holding a pair.
        #2;
        reset = 1'b0;
        #1;
        chk("async out_valid", {31'b0, v0}, 32'd0);
        chk("async busy", {31'b0, busy0}, 32'd0);
        chk("async done", {31'b0, done0}, 32'd0);
        chk("async A", a0, 32'h0);
        chk("async B", b0, 32'h0);
        chk("async sample_count", sc0, 32'd0);
        chk("async rejected_count", rc0, 32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("reseeded A", a0, 32'h1FC00000);
        chk("reseeded B", b0, 32'hA00487EE);
        wait_done("run3 done");

        // Restart from DONE: counts clear, sequence continues.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart count", sc0, 32'd0);
        chk("restart done", {31'b0, done0}, 32'd0);
        chk("restart busy", {31'b0, busy0}, 32'd1);
        wait_done("run4 done");
        chk("run4 count", sc0, 32'd4);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_operand_gen.md
Name: fp_operand_gen

Overview:
- Synthesizable stimulus source for the floating-point divider and error_cal path.
- Produces pseudo-random IEEE-754 single-precision operand pairs A/B from two independent LFSRs.
- Optionally filters out special or denormal encodings.
- Presents each pair over a valid/ready handshake, counts accepted pairs and stops after NUM_SAMPLES, so error runs can be done on-chip without a simulator random source.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- NUM_SAMPLES, 20000, number of accepted pairs per run; must be ≥1.
- SEED_A, 32'h3F800000, LFSR A reset value; a value of 0 is replaced by 1.
- SEED_B, 32'h40490FDB, LFSR B reset value; a value of 0 is replaced by 1.
- FILTER_SPECIAL, 1, when 1, reject any candidate whose A or B exponent is 8'h00 or 8'hFF.
- CNT_W, 32, width of sample_count and rejected_count.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- out_ready  in  1  consumer accepts the current pair.
- out_valid  out  1  A/B hold a valid pair.
- A  out  XLEN  dividend operand.
- B  out  XLEN  divisor operand.
- busy  out  1  high in GEN and HOLD.
- done  out  1  high in DONE.
- sample_count  out  CNT_W  pairs accepted in the current run.
- rejected_count  out  CNT_W  candidates discarded by the filter in the current run; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; A=0, B=0; out_valid=0, busy=0, done=0; both counts=0; lfsr_a=SEED_A, lfsr_b=SEED_B (0 replaced by 1).
- LFSR step, Galois right-shift with mask 32'h80200003 (x^32+x^22+x^2+x+1): next = lsb ? (cur>>1)^mask : cur>>1. Both LFSRs step together, only in GEN.
- IDLE: outputs quiet. start=1 → clear both counts, go to GEN.
- GEN (one cycle per candidate): candidate = stepped values (next_a, next_b).
  - Rejected (FILTER_SPECIAL=1 and exp_a or exp_b, bits[30:23], is 8'h00 or 8'hFF): increment rejected_count; stay in GEN.
  - Otherwise: register A=next_a, B=next_b; set out_valid=1; go to HOLD.
- HOLD: out_valid=1; A and B stay stable until out_ready=1.
  - Handshake (out_valid & out_ready on a rising edge): sample_count+1 and out_valid=0.
  - If the new count equals NUM_SAMPLES, go to DONE; otherwise go to GEN.
  - out_valid never drops without a handshake.
- Throughput: at most one pair every 2 cycles (GEN then HOLD). The first valid appears 1 cycle after start is sampled, when no rejections occur.
- DONE: done=1 and out_valid=0. A and B hold the last pair. Counts hold.
  - start=1 → clear counts, done=0, go to GEN.
  - The LFSRs are not reseeded, so the sequence continues.
- start while in GEN or HOLD is ignored.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-run (any state) returns all state to reset values immediately. The next run reproduces the seeded sequence from the start.
- No sign filtering: sign bits pass through as generated.
- Counter wrap is impossible for sample_count when NUM_SAMPLES < 2^CNT_W; rejected_count saturates.

Test Plan:
- Default seeds, FILTER_SPECIAL=1, start pulse, out_ready=1 → first out_valid 1 cycle after start with A=32'h1FC00000, B=32'hA00487EE; sample_count=1 after the handshake.
- Backpressure: out_ready=0 for 10 cycles after the first valid → out_valid stays 1; A/B unchanged (32'h1FC00000/32'hA00487EE); sample_count stays 0; LFSRs do not advance. Raise out_ready → one handshake, count=1.
- SEED_A=1, FILTER_SPECIAL=1 → first candidate A=32'h80200003 (exp 0) is rejected: rejected_count=1, no valid that cycle. With FILTER_SPECIAL=0 → A=32'h80200003 is presented as the first pair.
- NUM_SAMPLES=4, out_ready=1 → exactly 4 handshakes; done=1 and busy=0 the cycle after the 4th; sample_count=4; a 5th valid never appears. A second start → counts clear, the run continues from the next LFSR state.
- reset driven low while in HOLD → out_valid, busy, done, A, B and counts are 0 without waiting for a clock edge. Release, then start → first pair is again 32'h1FC00000/32'hA00487EE.
- start pulsed while in HOLD → no state change: counts, A and B are unaffected.
